// File: rtl/pulse_sched_pkg.sv
// Shared types and constants for the pulse scheduler.
//   state_e   : FSM state encoding (IDLE, PULSE, GAP)
//   MIN_WIDTH : shortest pulse the scheduler emits, in clk cycles
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned MIN_WIDTH = 1;

endpackage

// File: rtl/pulse_scheduler_if.sv
// Event/configuration/status bundle for the pulse scheduler.
//   req_pulse  : per-requester 1-cycle event pulse (source -> scheduler)
//   cfg_en     : enables new grants
//   cfg_width  : pulse high time in clk cycles (0 behaves as 1)
//   cfg_gap    : extra low cycles after each pulse
//   pulse_wide : stretched output pulse
//   pulse_id   : requester owning the current/last pulse
//   pending    : captured but not yet served events
//   busy       : scheduler not idle
//   drop       : 1-cycle flag per requester, event lost while already pending
// master = event source / configuration side, slave = scheduler.
interface pulse_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_pulse;
    logic               cfg_en;
    logic [CNT_W-1:0]   cfg_width;
    logic [CNT_W-1:0]   cfg_gap;
    logic               pulse_wide;
    logic [ID_W-1:0]    pulse_id;
    logic [NUM_REQ-1:0] pending;
    logic               busy;
    logic [NUM_REQ-1:0] drop;

    modport master (
        output req_pulse, cfg_en, cfg_width, cfg_gap,
        input  pulse_wide, pulse_id, pending, busy, drop
    );

    modport slave (
        input  req_pulse, cfg_en, cfg_width, cfg_gap,
        output pulse_wide, pulse_id, pending, busy, drop
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   ptr         : index of the last winner; search starts at ptr+1 and wraps
//   grant       : one-hot grant (all zero when no request)
//   grant_id    : index of the granted requester
//   grant_valid : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        // Offset NUM_REQ lands back on ptr itself, so the last winner has lowest priority.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((int'(ptr) + int'(off)) % int'(NUM_REQ));
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one stretched-pulse channel between NUM_REQ event sources.
// Each granted event becomes a pulse of max(cfg_width,1) cycles, followed by
// one IDLE evaluation cycle plus cfg_gap GAP cycles of low time, so a slow
// downstream edge detector sees one distinct edge per event.
// Ports:
//   clk : fast-domain clock
//   rst : synchronous active-high reset
//   bus : pulse_scheduler_if slave modport (events, config, status)
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 4
) (
    input logic              clk,
    input logic              rst,
    pulse_scheduler_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] drop_q, drop_d;
    logic               pulse_wide_q, pulse_wide_d;
    logic [ID_W-1:0]    pulse_id_q, pulse_id_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_valid;
    logic               grant_fire;
    logic [NUM_REQ-1:0] grant_vec;
    logic [CNT_W-1:0]   width_load;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (pending_q),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_id    (arb_id),
        .grant_valid (arb_valid)
    );

    assign grant_fire = (state_q == IDLE) && bus.cfg_en && arb_valid;
    assign grant_vec  = grant_fire ? arb_grant : '0;

    // Width counter counts down to zero, so load width-1 with 0 promoted to 1.
    assign width_load = (bus.cfg_width < CNT_W'(MIN_WIDTH)) ? '0
                                                            : bus.cfg_width - CNT_W'(MIN_WIDTH);

    // A new event on the grant cycle re-arms pending; otherwise a repeat is a drop.
    always_comb begin
        pending_d = (pending_q & ~grant_vec) | bus.req_pulse;
        drop_d    = bus.req_pulse & pending_q & ~grant_vec;
    end

    always_comb begin
        state_d      = state_q;
        pulse_wide_d = pulse_wide_q;
        pulse_id_d   = pulse_id_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;

        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d      = PULSE;
                    pulse_wide_d = 1'b1;
                    pulse_id_d   = arb_id;
                    ptr_d        = arb_id;
                    cnt_d        = width_load;
                    gap_d        = bus.cfg_gap;
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pulse_wide_d = 1'b0;
                    state_d      = (gap_q != '0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            default: begin
                state_d      = IDLE;
                pulse_wide_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            drop_q       <= '0;
            pulse_wide_q <= 1'b0;
            pulse_id_q   <= '0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
            ptr_q        <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            pulse_wide_q <= pulse_wide_d;
            pulse_id_q   <= pulse_id_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.pulse_wide = pulse_wide_q;
    assign bus.pulse_id   = pulse_id_q;
    assign bus.pending    = pending_q;
    assign bus.busy       = busy_q;
    assign bus.drop       = drop_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: reset state, single event latency,
// round-robin drain, drop/re-arm, width/gap edges, enable gating, mid-pulse reset.
module tb_pulse_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] exp_pend [4];

    always #5 clk = ~clk;

    pulse_scheduler_if #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) bus ();

    pulse_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_pulse = '0;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_pulse = '0;
        bus.cfg_en    = 1'b0;
        bus.cfg_width = '0;
        bus.cfg_gap   = '0;
        cyc(2);

        // Reset state
        check("rst_pw",   32'(bus.pulse_wide), 32'h0);
        check("rst_busy", 32'(bus.busy),       32'h0);
        check("rst_pend", 32'(bus.pending),    32'h0);
        check("rst_drop", 32'(bus.drop),       32'h0);
        check("rst_id",   32'(bus.pulse_id),   32'h0);

        // Single event, width 2, gap 0
        rst           = 1'b0;
        bus.cfg_en    = 1'b1;
        bus.cfg_width = 4'd2;
        bus.cfg_gap   = 4'd0;
        cyc(7);
        check("idle_pw", 32'(bus.pulse_wide), 32'h0);
        bus.req_pulse = 4'b0001;
        cyc();
        bus.req_pulse = 4'b0000;
        check("s_pend_t1", 32'(bus.pending),    32'h1);
        check("s_pw_t1",   32'(bus.pulse_wide), 32'h0);
        cyc();
        check("s_pw_t2",   32'(bus.pulse_wide), 32'h1);
        check("s_id_t2",   32'(bus.pulse_id),   32'h0);
        check("s_busy_t2", 32'(bus.busy),       32'h1);
        check("s_pend_t2", 32'(bus.pending),    32'h0);
        cyc();
        check("s_pw_t3",   32'(bus.pulse_wide), 32'h1);
        cyc();
        check("s_pw_t4",   32'(bus.pulse_wide), 32'h0);
        check("s_busy_t4", 32'(bus.busy),       32'h0);

        // Round-robin drain from reset pointer
        do_reset();
        bus.cfg_width = 4'd1;
        exp_pend[0] = 4'b1110;
        exp_pend[1] = 4'b1100;
        exp_pend[2] = 4'b1000;
        exp_pend[3] = 4'b0000;
        bus.req_pulse = 4'b1111;
        cyc();
        bus.req_pulse = 4'b0000;
        check("rr_pend0", 32'(bus.pending), 32'hf);
        cyc();
        for (int k = 0; k < 4; k++) begin
            check("rr_pw_hi", 32'(bus.pulse_wide), 32'h1);
            check("rr_id",    32'(bus.pulse_id),   32'(k));
            check("rr_pend",  32'(bus.pending),    32'(exp_pend[k]));
            cyc();
            check("rr_pw_lo", 32'(bus.pulse_wide), 32'h0);
            cyc();
        end
        check("rr_busy_end", 32'(bus.busy), 32'h0);

        // Drop: requester 2 pulses twice while requester 0 owns a 4-cycle pulse
        do_reset();
        bus.cfg_width = 4'd4;
        bus.req_pulse = 4'b0001;
        cyc();
        bus.req_pulse = 4'b0000;
        cyc();
        check("d_pw_own0", 32'(bus.pulse_wide), 32'h1);
        check("d_id_own0", 32'(bus.pulse_id),   32'h0);
        cyc();
        bus.req_pulse = 4'b0100;
        cyc();
        bus.req_pulse = 4'b0000;
        check("d_pend_first", 32'(bus.pending), 32'h4);
        check("d_drop_first", 32'(bus.drop),    32'h0);
        cyc();
        bus.req_pulse = 4'b0100;
        cyc();
        bus.req_pulse = 4'b0000;
        check("d_drop2",   32'(bus.drop),       32'h4);
        check("d_pw_gap",  32'(bus.pulse_wide), 32'h0);
        check("d_pend2",   32'(bus.pending),    32'h4);
        cyc();
        check("d_drop_clr", 32'(bus.drop),       32'h0);
        check("d_pw_id2",   32'(bus.pulse_wide), 32'h1);
        check("d_id2",      32'(bus.pulse_id),   32'h2);
        check("d_pend_clr", 32'(bus.pending),    32'h0);
        cyc(3);
        check("d_pw_last", 32'(bus.pulse_wide), 32'h1);
        cyc();
        check("d_pw_end",   32'(bus.pulse_wide), 32'h0);
        check("d_busy_end", 32'(bus.busy),       32'h0);
        cyc();
        check("d_no_second", 32'(bus.pulse_wide), 32'h0);

        // Re-arm: requester 0 pulses on its own grant cycle
        bus.cfg_width = 4'd1;
        bus.req_pulse = 4'b0001;
        cyc();
        check("ra_pend", 32'(bus.pending), 32'h1);
        cyc();
        bus.req_pulse = 4'b0000;
        check("ra_pw1",   32'(bus.pulse_wide), 32'h1);
        check("ra_pend1", 32'(bus.pending),    32'h1);
        check("ra_drop1", 32'(bus.drop),       32'h0);
        cyc();
        check("ra_pw_lo", 32'(bus.pulse_wide), 32'h0);
        cyc();
        check("ra_pw2",   32'(bus.pulse_wide), 32'h1);
        check("ra_id2",   32'(bus.pulse_id),   32'h0);
        check("ra_pend2", 32'(bus.pending),    32'h0);
        check("ra_drop2", 32'(bus.drop),       32'h0);
        cyc();
        check("ra_busy_end", 32'(bus.busy), 32'h0);

        // Width 0 behaves as 1
        bus.cfg_width = 4'd0;
        bus.req_pulse = 4'b0010;
        cyc();
        bus.req_pulse = 4'b0000;
        cyc();
        check("w0_pw", 32'(bus.pulse_wide), 32'h1);
        check("w0_id", 32'(bus.pulse_id),   32'h1);
        cyc();
        check("w0_pw_lo", 32'(bus.pulse_wide), 32'h0);
        check("w0_busy",  32'(bus.busy),       32'h0);

        // Width 15, gap 3, width changed mid-pulse
        bus.cfg_width = 4'd15;
        bus.cfg_gap   = 4'd3;
        bus.req_pulse = 4'b1000;
        cyc();
        bus.req_pulse = 4'b0000;
        cyc();
        check("w15_pw_first", 32'(bus.pulse_wide), 32'h1);
        check("w15_id",       32'(bus.pulse_id),   32'h3);
        bus.cfg_width = 4'd1;
        bus.req_pulse = 4'b0001;
        cyc();
        bus.req_pulse = 4'b0000;
        check("w15_pend", 32'(bus.pending),    32'h1);
        check("w15_pw",   32'(bus.pulse_wide), 32'h1);
        for (int i = 0; i < 13; i++) begin
            cyc();
            check("w15_pw_hold", 32'(bus.pulse_wide), 32'h1);
        end
        cyc();
        check("gap_pw_a",   32'(bus.pulse_wide), 32'h0);
        check("gap_busy_a", 32'(bus.busy),       32'h1);
        cyc(2);
        check("gap_pw_c",   32'(bus.pulse_wide), 32'h0);
        check("gap_busy_c", 32'(bus.busy),       32'h1);
        cyc();
        check("gap_pw_idle",   32'(bus.pulse_wide), 32'h0);
        check("gap_busy_idle", 32'(bus.busy),       32'h0);
        cyc();
        check("gap_next_pw", 32'(bus.pulse_wide), 32'h1);
        check("gap_next_id", 32'(bus.pulse_id),   32'h0);
        cyc();
        check("gap_next_w1", 32'(bus.pulse_wide), 32'h0);
        bus.cfg_gap = 4'd0;
        cyc(4);

        // Enable gating
        bus.cfg_en    = 1'b0;
        bus.req_pulse = 4'b1010;
        cyc();
        bus.req_pulse = 4'b0000;
        cyc(2);
        check("en_pw",   32'(bus.pulse_wide), 32'h0);
        check("en_busy", 32'(bus.busy),       32'h0);
        check("en_pend", 32'(bus.pending),    32'ha);
        bus.cfg_en = 1'b1;
        cyc();
        check("en_pw1",   32'(bus.pulse_wide), 32'h1);
        check("en_id1",   32'(bus.pulse_id),   32'h1);
        check("en_pend1", 32'(bus.pending),    32'h8);
        cyc();
        check("en_lo1", 32'(bus.pulse_wide), 32'h0);
        check("en_id_hold", 32'(bus.pulse_id), 32'h1);
        cyc();
        check("en_pw3",   32'(bus.pulse_wide), 32'h1);
        check("en_id3",   32'(bus.pulse_id),   32'h3);
        check("en_pend3", 32'(bus.pending),    32'h0);
        cyc();
        check("en_lo3", 32'(bus.pulse_wide), 32'h0);

        // Reset during cycle 3 of a 6-cycle pulse
        bus.cfg_width = 4'd6;
        bus.req_pulse = 4'b1000;
        cyc();
        bus.req_pulse = 4'b0000;
        cyc();
        check("mr_pw",  32'(bus.pulse_wide), 32'h1);
        check("mr_id",  32'(bus.pulse_id),   32'h3);
        bus.req_pulse = 4'b0110;
        cyc();
        bus.req_pulse = 4'b0000;
        check("mr_pend", 32'(bus.pending), 32'h6);
        cyc();
        rst           = 1'b1;
        bus.req_pulse = 4'b0001;
        cyc();
        check("mr_rst_pw",   32'(bus.pulse_wide), 32'h0);
        check("mr_rst_pend", 32'(bus.pending),    32'h0);
        check("mr_rst_busy", 32'(bus.busy),       32'h0);
        check("mr_rst_id",   32'(bus.pulse_id),   32'h0);
        rst           = 1'b0;
        bus.req_pulse = 4'b0000;
        cyc();
        check("mr_discard", 32'(bus.pending),    32'h0);
        check("mr_idle_pw", 32'(bus.pulse_wide), 32'h0);
        bus.req_pulse = 4'b0110;
        cyc();
        bus.req_pulse = 4'b0000;
        check("mr_pend2", 32'(bus.pending), 32'h6);
        cyc();
        check("mr_first_pw",   32'(bus.pulse_wide), 32'h1);
        check("mr_first_id",   32'(bus.pulse_id),   32'h1);
        check("mr_first_pend", 32'(bus.pending),    32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
